// File: rtl/branch_control.sv
// branch_control: resolves conditional branches against the ALU flags and drives
// the PC redirect (pc_control/jump_offset) plus the wrong-path flush window.
module branch_control #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flags_we,
    input  logic [3:0] alu_flags,
    input  logic       br_valid,
    input  logic [2:0] br_cond,
    input  logic [7:0] br_offset,
    output logic       br_ready,
    output logic [7:0] pc_control,
    output logic [7:0] jump_offset,
    output logic       flush,
    output logic [7:0] taken_count
);
    typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;
    state_t state, state_n;
    logic [3:0] flags_q, flags, cnt, cnt_n;
    logic [7:0] hits;
    logic take;
    // flags = {Z,N,C,V}; a same-cycle flag write is forwarded into the evaluation
    assign flags = flags_we ? alu_flags : flags_q;
    assign hits = {!flags[1], flags[1], !(flags[2] ^ flags[0]), flags[2] ^ flags[0],
                   !flags[3], flags[3], 2'b10};
    assign br_ready = state == IDLE;
    assign take = br_valid && br_ready && hits[br_cond];
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        case (state)
            IDLE: state_n = take ? REDIRECT : IDLE;
            REDIRECT: begin
                state_n = FLUSH_CYCLES == 0 ? IDLE : FLUSH;
                cnt_n = 4'(FLUSH_CYCLES);
            end
            FLUSH: begin
                cnt_n = cnt - 4'd1;
                state_n = cnt == 4'd1 ? IDLE : FLUSH;
            end
            default: state_n = IDLE;
        endcase
    end
    // outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            flags_q <= '0;
            pc_control <= '0;
            jump_offset <= '0;
            flush <= 1'b0;
            taken_count <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            if (flags_we) flags_q <= alu_flags;
            pc_control <= state_n == REDIRECT ? 8'hFF : 8'h00;
            jump_offset <= state_n == REDIRECT ? br_offset : 8'h00;
            flush <= state_n != IDLE;
            taken_count <= taken_count + 8'(take);
        end
    end
endmodule

// File: doc/branch_control.md
Name: branch_control

Overview:
Upstream neighbour of the program counter. Resolves conditional branches issued by decode against the ALU condition flags. Drives the PC's pc_control mask and jump_offset, so the PC computes next = pc + 1 + offset on a taken branch. Asserts flush so fetch/decode squash the wrong-path instructions already in flight.

Parameters:
FLUSH_CYCLES, 2, cycles flush stays high after the redirect cycle; legal range 0..15.

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  asynchronous active-high reset
flags_we  input  1  write strobe for the flag register
alu_flags  input  4  {Z,N,C,V} from the ALU
br_valid  input  1  decode presents a branch this cycle
br_cond  input  3  condition code, see Behaviour
br_offset  input  8  two's-complement jump offset
br_ready  output  1  block can accept a branch this cycle
pc_control  output  8  8'hFF on the redirect cycle, else 8'h00
jump_offset  output  8  br_offset of the taken branch on the redirect cycle, else 8'h00
flush  output  1  squash in-flight fetch/decode instructions
taken_count  output  8  number of taken branches, wraps 255->0

Behaviour:
- Reset (async, any state, including mid-REDIRECT/FLUSH):
  - state=IDLE, flag register=0, flush counter=0.
  - pc_control=0, jump_offset=0, flush=0, taken_count=0, br_ready=1 (decoded from IDLE).
- Flag register: loads alu_flags on posedge when flags_we=1.
- Effective flags for evaluation:
  - alu_flags when flags_we=1 in the same cycle (forwarded).
  - Otherwise the flag register.
- Conditions:
  - 000 never
  - 001 always
  - 010 EQ (Z)
  - 011 NE (!Z)
  - 100 LT (N^V)
  - 101 GE (!(N^V))
  - 110 CS (C)
  - 111 CC (!C)
- Handshake:
  - A branch is accepted on posedge when br_valid & br_ready.
  - br_ready=1 only in IDLE.
  - br_valid while br_ready=0 is ignored, with no side effects. Decode must hold it.
- FSM states: IDLE, REDIRECT, FLUSH.
  - IDLE, accepted and taken: next state REDIRECT; register jump_offset<=br_offset; taken_count+1.
  - IDLE, accepted and not taken: stay IDLE; outputs stay 0; taken_count unchanged.
  - REDIRECT (exactly 1 cycle):
    - pc_control=8'hFF, jump_offset=offset, flush=1.
    - The PC applies the offset at the posedge ending this cycle.
    - Next state: FLUSH with counter=FLUSH_CYCLES, or IDLE if FLUSH_CYCLES=0.
  - FLUSH:
    - pc_control=0, jump_offset=0, flush=1.
    - Counter decrements each cycle; leave to IDLE in the cycle the counter reaches 1.
    - flush is therefore high for exactly FLUSH_CYCLES cycles after REDIRECT.
- Outputs:
  - All outputs are registered except br_ready, which is decoded from state.
  - Latency from accept to pc_control=FF is 1 cycle.
- Arithmetic:
  - Offset is passed through unmodified; the PC wraps mod 256.
  - Offset is relative to the PC value in the redirect cycle; decode compensates.
- Back-to-back branches:
  - The next branch can be accepted in the first IDLE cycle after FLUSH.
  - Minimum spacing between taken branches is 2+FLUSH_CYCLES cycles.
- flags_we during REDIRECT/FLUSH: the flag register still updates normally.

Test Plan:
- Reset, then idle 3 cycles -> pc_control=00, jump_offset=00, flush=0, br_ready=1, taken_count=0.
- br_valid, cond=001, offset=8'h05 (FLUSH_CYCLES=2):
  - Next cycle: pc_control=FF, jump_offset=05, flush=1.
  - Then 2 cycles: flush=1, pc_control=0.
  - Then IDLE; taken_count=1.
  - Companion PC at 8'h10 in the redirect cycle goes to 8'h16.
- Forwarding: flag register Z=0; same cycle flags_we=1, alu_flags Z=1, br_valid, cond=010, offset=8'hFE -> taken, jump_offset=FE next cycle. Repeat with cond=011 -> not taken, pc_control stays 00, br_ready stays 1.
- LT/GE with {N,V}={1,0} then {1,1}:
  - cond=100: taken, then not taken.
  - cond=101: not taken, then taken.
- br_valid held high with cond=001 across the whole FLUSH window -> only one acceptance per window, taken_count increments once per 4 cycles, no pc_control pulse during flush.
- Wrap and reset:
  - 256 taken branches -> taken_count reads 0.
  - Assert reset asynchronously during REDIRECT -> pc_control, flush and jump_offset drop to 0 immediately, without waiting for a clock edge; state IDLE after release.
